// File: rtl/mac_seq_ctrl.sv
// Sequences one signed MAC lane through a dot product of len elements; MAC_SEQ_BIAS_EN folds a start-time bias in via mac_ci.
// Latency: out_valid len + MAC_LAT + 1 cycles after start with gap-free operands; len == 0 completes the next cycle.
// Backpressure: in_ready only while operands are owed; result held in DONE until out_ready, start ignored unless idle.
module mac_seq_ctrl #(
    parameter int DW      = 8,
    parameter int CW      = 16,
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 4,
    parameter int CI_DLY  = 2,
    parameter int ACC_W   = CW + LEN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [CW-1:0]    bias,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_x,
    input  logic [DW-1:0]    in_w,
    output logic [DW-1:0]    mac_xi,
    output logic [DW-1:0]    mac_wi,
    output logic             mac_w_en,
    output logic [CW-1:0]    mac_ci,
    input  logic [CW:0]      mac_co,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q;
    logic [MAC_LAT-1:0] tag_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   start_acc;
    logic [ACC_W-1:0]   co_ext;
    logic               issue;
    logic               start_ok;

    assign start_ok = (state_q == IDLE) && start;
    assign co_ext   = {{(ACC_W-CW-1){mac_co[CW]}}, mac_co};

    always_comb begin
        state_d  = state_q;
        in_ready = (state_q == STREAM) && (remaining_q != '0);
        issue    = in_valid && in_ready;
        case (state_q)
            IDLE:    if (start) state_d = (len != '0) ? STREAM : DONE;
            STREAM:  if (issue && remaining_q == LEN_W'(1)) state_d = DRAIN;
            // The oldest tag is consumed this cycle, so only younger bits matter.
            DRAIN:   if (tag_q[MAC_LAT-2:0] == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mac_xi    = issue ? in_x : '0;
    assign mac_wi    = issue ? in_w : '0;
    assign mac_w_en  = issue;
    assign out_valid = (state_q == DONE);
    assign out_data  = acc_q;
    assign busy      = (state_q != IDLE) && !((state_q == DONE) && out_ready);

`ifdef MAC_SEQ_BIAS_EN
    logic [CI_DLY-1:0][CW-1:0] ci_line_q;
    logic [CW-1:0]             bias_q;
    logic                      first_q;

    assign start_acc = (len == '0) ? {{(ACC_W-CW){bias[CW-1]}}, bias} : '0;
    assign mac_ci    = ci_line_q[CI_DLY-1];

    // The bias rides alongside the first element so the MAC adds it exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci_line_q <= '0;
            bias_q    <= '0;
            first_q   <= 1'b0;
        end else begin
            if (start_ok) begin
                bias_q  <= bias;
                first_q <= 1'b1;
            end else if (issue) begin
                first_q <= 1'b0;
            end
            ci_line_q[0] <= (issue && first_q) ? bias_q : '0;
            for (int i = 1; i < CI_DLY; i++) ci_line_q[i] <= ci_line_q[i-1];
        end
    end
`else
    logic unused_bias;

    assign unused_bias = ^bias;
    assign start_acc   = '0;
    assign mac_ci      = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tag_q       <= '0;
            acc_q       <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= {tag_q[MAC_LAT-2:0], issue};
            if (start_ok) begin
                remaining_q <= len;
                acc_q       <= start_acc;
            end else begin
                if (issue) remaining_q <= remaining_q - LEN_W'(1);
                if (tag_q[MAC_LAT-1]) acc_q <= acc_q + co_ext;
            end
        end
    end

endmodule
